mem_stage: RTL

- Memory-access stage directly downstream of the execute stage.
- Consumes the EX result (write address, write enable, ALU result, which is also the effective address for loads/stores) and the load/store control.
- Runs a req/ack transaction on the data-memory bus and aligns, sign-extends or zero-extends load data.
- Registers the result toward write-back, and asserts stall_req_o to freeze upstream stages while a bus access is outstanding.

---
 rtl/mem_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; drives a req/ack data bus, aligns and extends load data, registers results for write-back.
// Ports: clk/rst (sync, active-high); EX inputs valid_i, waddr_i, we_i, wdata_i (result / effective address),
// mem_op_i, store_data_i; stall_req_o (combinational); data bus mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
// mem_wdata_o, mem_ack_i, mem_rdata_i; write-back outputs valid_o, waddr_o, we_o, wdata_o, misalign_o.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic               we_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [3:0]         mem_op_i,
  input  logic [DATA_W-1:0]  store_data_i,
  output logic               stall_req_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [DATA_W-1:0]  mem_addr_o,
  output logic [3:0]         mem_be_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic               mem_ack_i,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  output logic               valid_o,
  output logic [RADDR_W-1:0] waddr_o,
  output logic               we_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic               misalign_o
);
  typedef enum logic {IDLE, BUS} state_t;
  localparam logic [3:0] LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4, LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;
  state_t state_q, state_d;
  logic [3:0] cap_op, cap_op_d;
  logic [DATA_W-1:0] cap_addr, cap_addr_d;
  logic [RADDR_W-1:0] cap_waddr, cap_waddr_d;
  logic cap_we, cap_we_d;
  logic req_d, bwe_d, valid_d, we_d, mis_d;
  logic [DATA_W-1:0] addr_d, bwdata_d, wdata_d;
  logic [3:0] be_d;
  logic [RADDR_W-1:0] waddr_d;
  logic is_load, is_store, aligned, cap_load;
  logic [1:0] off;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic [DATA_W-1:0] ext;
  assign is_load = mem_op_i inside {LB, LH, LW, LBU, LHU};
  assign is_store = mem_op_i inside {SB, SH, SW};
  assign off = wdata_i[1:0];
  assign aligned = (mem_op_i inside {LH, LHU, SH}) ? !off[0] : (mem_op_i inside {LW, SW}) ? off == 2'b00 : 1'b1;
  assign stall_req_o = (state_q == IDLE && valid_i && (is_load || is_store) && aligned) || (state_q == BUS && !mem_ack_i);
  // Lane selection uses the offset captured at accept time, since the bus word arrives later.
  assign cap_load = cap_op inside {LB, LH, LW, LBU, LHU};
  assign rbyte = mem_rdata_i[8*cap_addr[1:0] +: 8];
  assign rhalf = mem_rdata_i[16*cap_addr[1] +: 16];
  assign ext = (cap_op == LB)  ? {{(DATA_W-8){rbyte[7]}}, rbyte} :
               (cap_op == LBU) ? {{(DATA_W-8){1'b0}}, rbyte} :
               (cap_op == LH)  ? {{(DATA_W-16){rhalf[15]}}, rhalf} :
               (cap_op == LHU) ? {{(DATA_W-16){1'b0}}, rhalf} : mem_rdata_i;
  always_comb begin
    state_d = state_q;
    cap_op_d = cap_op;
    cap_addr_d = cap_addr;
    cap_waddr_d = cap_waddr;
    cap_we_d = cap_we;
    req_d = mem_req_o;
    bwe_d = mem_we_o;
    addr_d = mem_addr_o;
    be_d = mem_be_o;
    bwdata_d = mem_wdata_o;
    valid_d = 1'b0;
    we_d = 1'b0;
    mis_d = 1'b0;
    waddr_d = waddr_o;
    wdata_d = wdata_o;
    if (state_q == IDLE && valid_i) begin
      if (!(is_load || is_store)) begin
        valid_d = 1'b1;
        waddr_d = waddr_i;
        we_d = we_i;
        wdata_d = wdata_i;
      end else if (!aligned) begin
        valid_d = 1'b1;
        waddr_d = waddr_i;
        wdata_d = wdata_i;
        mis_d = 1'b1;
      end else begin
        state_d = BUS;
        req_d = 1'b1;
        bwe_d = is_store;
        addr_d = {wdata_i[DATA_W-1:2], 2'b00};
        be_d = (mem_op_i == SB) ? 4'b0001 << off : (mem_op_i == SH) ? 4'b0011 << off : 4'b1111;
        bwdata_d = (mem_op_i == SB) ? {(DATA_W/8){store_data_i[7:0]}} :
                   (mem_op_i == SH) ? {(DATA_W/16){store_data_i[15:0]}} : store_data_i;
        cap_op_d = mem_op_i;
        cap_addr_d = wdata_i;
        cap_waddr_d = waddr_i;
        cap_we_d = we_i;
      end
    end else if (state_q == BUS && mem_ack_i) begin
      state_d = IDLE;
      req_d = 1'b0;
      bwe_d = 1'b0;
      valid_d = 1'b1;
      waddr_d = cap_waddr;
      we_d = cap_load && cap_we;
      wdata_d = cap_load ? ext : cap_addr;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cap_op <= '0;
      cap_addr <= '0;
      cap_waddr <= '0;
      cap_we <= 1'b0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_be_o <= '0;
      mem_wdata_o <= '0;
      valid_o <= 1'b0;
      we_o <= 1'b0;
      misalign_o <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else begin
      state_q <= state_d;
      cap_op <= cap_op_d;
      cap_addr <= cap_addr_d;
      cap_waddr <= cap_waddr_d;
      cap_we <= cap_we_d;
      mem_req_o <= req_d;
      mem_we_o <= bwe_d;
      mem_addr_o <= addr_d;
      mem_be_o <= be_d;
      mem_wdata_o <= bwdata_d;
      valid_o <= valid_d;
      we_o <= we_d;
      misalign_o <= mis_d;
      waddr_o <= waddr_d;
      wdata_o <= wdata_d;
    end
  end
endmodule
